// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
package booth_pkg;

  localparam int unsigned N_DEF = 8;

  typedef enum logic [2:0] {
    StEspera   = 3'd0,
    StCarga    = 3'd1,
    StSuma     = 3'd2,
    StDesplaza = 3'd3,
    StFin      = 3'd4
  } booth_state_e;

  // Width needed to hold the iteration count 0..n.
  function automatic int unsigned cuenta_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/booth_datapath.sv
// Booth working registers: A accumulator, Q/Q_1 multiplier pair, M multiplicand,
// plus the add/subtract and arithmetic right shift of {A,Q,Q_1}.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic           add_i,
  input  logic           sub_i,
  input  logic           shift_i,
  input  logic [N-1:0]   multiplicador_i,
  input  logic [N-1:0]   multiplicando_i,
  output logic           q0_o,
  output logic           q_1_o,
  output logic [2*N-1:0] aq_o
);

  // A and M carry one extra bit so that subtracting M = -2^(N-1) cannot overflow.
  logic [N:0]   a_q, a_d, m_q, m_d;
  logic [N-1:0] q_q, q_d;
  logic         q1_q, q1_d;

  always_comb begin
    a_d  = a_q;
    m_d  = m_q;
    q_d  = q_q;
    q1_d = q1_q;
    if (load_i) begin
      a_d  = '0;
      q_d  = multiplicador_i;
      q1_d = 1'b0;
      m_d  = {multiplicando_i[N-1], multiplicando_i};
    end else if (add_i) begin
      a_d = a_q + m_q;
    end else if (sub_i) begin
      a_d = a_q - m_q;
    end else if (shift_i) begin
      a_d  = {a_q[N], a_q[N:1]};
      q_d  = {a_q[0], q_q[N-1:1]};
      q1_d = q_q[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q  <= '0;
      m_q  <= '0;
      q_q  <= '0;
      q1_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      m_q  <= m_d;
      q_q  <= q_d;
      q1_q <= q1_d;
    end
  end

  assign q0_o  = q_q[0];
  assign q_1_o = q1_q;
  assign aq_o  = {a_q[N-1:0], q_q};

endmodule

// File: rtl/booth_control.sv
// Sequencer for the radix-2 Booth signed multiplier: edge-detects the start request,
// steps the datapath through N add/shift iterations and registers the product.
module booth_control
  import booth_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic           CLK100MHZ,
  input  logic           reset_entrada,
  input  logic           inicio,
  input  logic [N-1:0]   multiplicador,
  input  logic [N-1:0]   multiplicando,
  output logic [2*N-1:0] producto,
  output logic           listo,
  output logic           ocupado
);

  localparam int unsigned CW = cuenta_width(N);
  localparam logic [CW-1:0] CuentaIni = CW'(N);

  booth_state_e   state_q, state_d;
  logic [CW-1:0]  cuenta_q, cuenta_d;
  logic [2*N-1:0] producto_q, producto_d;
  logic           listo_q, listo_d;
  logic           ocupado_q, ocupado_d;
  logic           inicio_prev_q;

  logic           load, add, sub, shift;
  logic           q0, q_1;
  logic [2*N-1:0] aq;
  logic           start;

  assign start = inicio & ~inicio_prev_q;

  booth_datapath #(
    .N (N)
  ) u_datapath (
    .clk_i           (CLK100MHZ),
    .rst_ni          (reset_entrada),
    .load_i          (load),
    .add_i           (add),
    .sub_i           (sub),
    .shift_i         (shift),
    .multiplicador_i (multiplicador),
    .multiplicando_i (multiplicando),
    .q0_o            (q0),
    .q_1_o           (q_1),
    .aq_o            (aq)
  );

  always_comb begin
    state_d    = state_q;
    cuenta_d   = cuenta_q;
    producto_d = producto_q;
    listo_d    = listo_q;
    ocupado_d  = ocupado_q;
    load       = 1'b0;
    add        = 1'b0;
    sub        = 1'b0;
    shift      = 1'b0;
    case (state_q)
      StEspera: begin
        if (start) state_d = StCarga;
      end
      StCarga: begin
        load      = 1'b1;
        cuenta_d  = CuentaIni;
        listo_d   = 1'b0;
        ocupado_d = 1'b1;
        state_d   = StSuma;
      end
      StSuma: begin
        add     = ({q0, q_1} == 2'b01);
        sub     = ({q0, q_1} == 2'b10);
        state_d = StDesplaza;
      end
      StDesplaza: begin
        shift    = 1'b1;
        cuenta_d = cuenta_q - 1'b1;
        state_d  = (cuenta_q == CW'(1)) ? StFin : StSuma;
      end
      StFin: begin
        producto_d = aq;
        listo_d    = 1'b1;
        ocupado_d  = 1'b0;
        state_d    = StEspera;
      end
      default: begin
        state_d   = StEspera;
        ocupado_d = 1'b0;
      end
    endcase
  end

  // inicio_prev resets high so a start held through reset is not seen as an edge.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset_entrada) begin
      state_q       <= StEspera;
      cuenta_q      <= '0;
      producto_q    <= '0;
      listo_q       <= 1'b0;
      ocupado_q     <= 1'b0;
      inicio_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cuenta_q      <= cuenta_d;
      producto_q    <= producto_d;
      listo_q       <= listo_d;
      ocupado_q     <= ocupado_d;
      inicio_prev_q <= inicio;
    end
  end

  assign producto = producto_q;
  assign listo    = listo_q;
  assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_booth_control.sv
// Directed bench for booth_control: table of signed products plus start/reset corner cases.
module tb_booth_control;

  logic        clk;
  logic        rst_n;
  logic        inicio;
  logic [7:0]  mq;
  logic [7:0]  mm;
  logic [15:0] producto;
  logic        listo;
  logic        ocupado;

  int checks = 0;
  int errors = 0;

  booth_control #(
    .N (8)
  ) dut (
    .CLK100MHZ     (clk),
    .reset_entrada (rst_n),
    .inicio        (inicio),
    .multiplicador (mq),
    .multiplicando (mm),
    .producto      (producto),
    .listo         (listo),
    .ocupado       (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  m;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start with a one-cycle inicio pulse; lat = edges after E0 until listo, -1 on timeout.
  task automatic run_op(input logic [7:0] q, input logic [7:0] m, output int lat);
    @(negedge clk);
    mq     = q;
    mm     = m;
    inicio = 1'b1;
    lat    = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) inicio = 1'b0;
      if (i >= 2 && listo) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic idle_quiet(input int cycles, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (ocupado) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    int lat;
    int rises;
    logic prev_oc;

    vecs[0] = '{q: 8'd3,    m: 8'd5,    exp: 16'h000F};
    vecs[1] = '{q: 8'hFD,   m: 8'd5,    exp: 16'hFFF1};
    vecs[2] = '{q: 8'd127,  m: 8'h80,   exp: 16'hC080};
    vecs[3] = '{q: 8'h80,   m: 8'h80,   exp: 16'h4000};
    vecs[4] = '{q: 8'd0,    m: 8'hB3,   exp: 16'h0000};
    vecs[5] = '{q: 8'hFE,   m: 8'hFE,   exp: 16'h0004};
    vecs[6] = '{q: 8'hFF,   m: 8'hFF,   exp: 16'h0001};
    vecs[7] = '{q: 8'd1,    m: 8'h80,   exp: 16'hFF80};
    vecs[8] = '{q: 8'h80,   m: 8'd127,  exp: 16'hC080};
    vecs[9] = '{q: 8'd100,  m: 8'd100,  exp: 16'h2710};

    // Reset with inicio already high: release must not start an operation.
    rst_n  = 1'b0;
    inicio = 1'b1;
    mq     = 8'd0;
    mm     = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_producto", producto, 16'h0000);
    check("reset_listo", listo, 1'b0);
    check("reset_ocupado", ocupado, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_quiet(30, "held_start_after_reset");
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      run_op(vecs[k].q, vecs[k].m, lat);
      check($sformatf("prod_%0d", k), producto, vecs[k].exp);
      check($sformatf("lat_%0d", k), lat, 18);
      check($sformatf("ocupado_done_%0d", k), ocupado, 1'b0);
    end

    // inicio held high for 100 clocks yields exactly one operation.
    @(negedge clk);
    mq      = 8'd7;
    mm      = 8'd6;
    inicio  = 1'b1;
    rises   = 0;
    prev_oc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (ocupado && !prev_oc) rises++;
      prev_oc = ocupado;
    end
    check("held_one_op", rises, 1);
    check("held_prod", producto, 16'h002A);
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);

    // New start edge and operand change mid-operation are ignored.
    @(negedge clk);
    mq     = 8'd3;
    mm     = 8'd5;
    inicio = 1'b1;
    lat    = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) inicio = 1'b0;
      if (i == 6) begin
        inicio = 1'b1;
        mq     = 8'h7F;
        mm     = 8'h80;
      end
      if (i >= 2 && listo) begin
        lat = i - 1;
        break;
      end
    end
    check("busy_prod", producto, 16'h000F);
    check("busy_lat", lat, 18);
    idle_quiet(20, "busy_edge_not_queued");
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);

    // Result retention: old product visible and listo low while the next op runs.
    run_op(8'd3, 8'd5, lat);
    check("ret_first", producto, 16'h000F);
    @(negedge clk);
    mq     = 8'hFE;
    mm     = 8'hFE;
    inicio = 1'b1;
    lat    = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) inicio = 1'b0;
      if (ocupado) begin
        check("ret_hold_prod", producto, 16'h000F);
        check("ret_hold_listo", listo, 1'b0);
      end
      if (i >= 2 && listo) begin
        lat = i - 1;
        break;
      end
    end
    check("ret_final", producto, 16'h0004);
    check("ret_lat", lat, 18);

    // Reset at clock 9 of an operation aborts to reset values.
    @(negedge clk);
    mq     = 8'd3;
    mm     = 8'd5;
    inicio = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) inicio = 1'b0;
    end
    check("pre_abort_ocupado", ocupado, 1'b1);
    @(negedge clk);
    rst_n  = 1'b0;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ocupado", ocupado, 1'b0);
    check("abort_listo", listo, 1'b0);
    check("abort_producto", producto, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    idle_quiet(30, "abort_held_start");
    check("abort_producto_stays", producto, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
